// File: rtl/cv_ctrl_pkg.sv
// Shared constants for the ColecoVision controller-port front end: keypad codes,
// joystick bit positions and the quadrature phase type with its step helpers.
package cv_ctrl_pkg;

  localparam int unsigned JOY_U_C      = 0;
  localparam int unsigned JOY_D_C      = 1;
  localparam int unsigned JOY_L_C      = 2;
  localparam int unsigned JOY_R_C      = 3;
  localparam int unsigned JOY_FIRE1_C  = 4;
  localparam int unsigned JOY_FIRE2_C  = 5;
  localparam int unsigned JOY_STAR_C   = 6;
  localparam int unsigned JOY_HASH_C   = 7;
  localparam int unsigned JOY_KEY0_C   = 8;
  localparam int unsigned JOY_PURPLE_C = 18;
  localparam int unsigned JOY_BLUE_C   = 19;

  // Pin codes as {p1,p2,p3,p4}; 4'b1111 means no key.
  localparam logic [3:0] cv_key_0_c      = 4'b0011;
  localparam logic [3:0] cv_key_1_c      = 4'b1110;
  localparam logic [3:0] cv_key_2_c      = 4'b1101;
  localparam logic [3:0] cv_key_3_c      = 4'b0110;
  localparam logic [3:0] cv_key_4_c      = 4'b0001;
  localparam logic [3:0] cv_key_5_c      = 4'b1001;
  localparam logic [3:0] cv_key_6_c      = 4'b0111;
  localparam logic [3:0] cv_key_7_c      = 4'b1100;
  localparam logic [3:0] cv_key_8_c      = 4'b1000;
  localparam logic [3:0] cv_key_9_c      = 4'b1011;
  localparam logic [3:0] cv_key_star_c   = 4'b1010;
  localparam logic [3:0] cv_key_hash_c   = 4'b0101;
  localparam logic [3:0] cv_key_purple_c = 4'b0010;
  localparam logic [3:0] cv_key_blue_c   = 4'b0100;
  localparam logic [3:0] cv_key_none_c   = 4'b1111;

  localparam int unsigned NUM_KEYS_C = 14;

  // Index order is also priority order, index 0 highest.
  localparam logic [3:0] KEY_CODES_C [NUM_KEYS_C] = '{
    cv_key_0_c, cv_key_1_c, cv_key_2_c, cv_key_3_c, cv_key_4_c,
    cv_key_5_c, cv_key_6_c, cv_key_7_c, cv_key_8_c, cv_key_9_c,
    cv_key_star_c, cv_key_hash_c, cv_key_purple_c, cv_key_blue_c
  };

  typedef logic [1:0] phase_t;
  localparam phase_t PH_IDLE = 2'b11;

  function automatic logic [3:0] key_code(input logic [NUM_KEYS_C-1:0] keys);
    logic [3:0] code;
    code = cv_key_none_c;
    for (int k = NUM_KEYS_C - 1; k >= 0; k--) begin
      code = keys[k] ? KEY_CODES_C[k] : code;
    end
    return code;
  endfunction

  // Forward walk of (A,B): 11 -> 01 -> 00 -> 10 -> 11.
  function automatic phase_t phase_fwd(input phase_t ph);
    phase_t nxt;
    case (ph)
      2'b11:   nxt = 2'b01;
      2'b01:   nxt = 2'b00;
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      default: nxt = PH_IDLE;
    endcase
    return nxt;
  endfunction

  function automatic phase_t phase_rev(input phase_t ph);
    phase_t nxt;
    case (ph)
      2'b11:   nxt = 2'b10;
      2'b10:   nxt = 2'b00;
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      default: nxt = PH_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cv_ctrl_ports_if.sv
// Bundle of frontend inputs and controller pins shared between the frontend
// (master) and the controller-port block (slave).
interface cv_ctrl_ports_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0][31:0] joystick;
  logic [NUM_PORTS-1:0][8:0]  spinner;
  logic [NUM_PORTS-1:0]       spin_en;
  logic [NUM_PORTS-1:0]       ctrl_p5_n;
  logic [NUM_PORTS-1:0]       ctrl_p8_n;
  logic [NUM_PORTS-1:0][3:0]  ctrl_p1_4;
  logic [NUM_PORTS-1:0]       ctrl_p6;
  logic [NUM_PORTS-1:0]       ctrl_p7;
  logic [NUM_PORTS-1:0]       ctrl_p9;

  modport master (
    output joystick, spinner, spin_en, ctrl_p5_n, ctrl_p8_n,
    input  ctrl_p1_4, ctrl_p6, ctrl_p7, ctrl_p9
  );

  modport slave (
    input  joystick, spinner, spin_en, ctrl_p5_n, ctrl_p8_n,
    output ctrl_p1_4, ctrl_p6, ctrl_p7, ctrl_p9
  );
endinterface

// File: rtl/cv_spin_quad.sv
// Per-port spinner emulation: saturating movement accumulator drained one count
// per quadrature step, with steps paced by a ce_10m7 divider.
module cv_spin_quad
  import cv_ctrl_pkg::*;
#(
  parameter int SPIN_DIV = 64,
  parameter int ACC_MAX  = 127
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_10m7,
  input  logic       spin_en,
  input  logic [8:0] spinner,
  output logic       quad_a,
  output logic       quad_b
);

  localparam int ACC_W = $clog2(ACC_MAX + 1) + 1;
  localparam int CNT_W = $clog2(SPIN_DIV);
  localparam int SUM_W = ACC_W + 10;

  logic signed [ACC_W-1:0] acc_r, acc_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  phase_t                  phase_r, phase_nxt_s;
  logic                    tog_r;

  logic                    new_s, tc_s, step_s;
  logic signed [SUM_W-1:0] acc_ext_s, delta_s, dir_s, sum_s, max_s;

  // Step decision, accumulator update with single saturation, phase advance
  always_comb begin
    new_s     = spinner[8] ^ tog_r;
    tc_s      = ce_10m7 && (cnt_r == CNT_W'(SPIN_DIV - 1));
    step_s    = tc_s && (acc_r != '0);
    acc_ext_s = SUM_W'(acc_r);
    delta_s   = SUM_W'($signed(spinner[7:0]));
    max_s     = SUM_W'(ACC_MAX);
    dir_s     = '0;
    if (step_s) begin
      dir_s = acc_r[ACC_W-1] ? {SUM_W{1'b1}} : SUM_W'(1);
    end else begin
      dir_s = '0;
    end
    sum_s = new_s ? (acc_ext_s + delta_s - dir_s) : (acc_ext_s - dir_s);

    acc_nxt_s = '0;
    if (sum_s > max_s) begin
      acc_nxt_s = ACC_W'(max_s);
    end else if (sum_s < -max_s) begin
      acc_nxt_s = ACC_W'(-max_s);
    end else begin
      acc_nxt_s = ACC_W'(sum_s);
    end

    cnt_nxt_s = cnt_r;
    if (ce_10m7) begin
      cnt_nxt_s = tc_s ? '0 : cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end

    phase_nxt_s = phase_r;
    if (step_s) begin
      phase_nxt_s = acc_r[ACC_W-1] ? phase_rev(phase_r) : phase_fwd(phase_r);
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Spinner state; the toggle copy always follows its input when not sampling
  always_ff @(posedge clk_sys) begin
    if (reset || !spin_en) begin
      acc_r   <= '0;
      cnt_r   <= '0;
      phase_r <= PH_IDLE;
      tog_r   <= spinner[8];
    end else begin
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
      tog_r   <= spinner[8];
    end
  end

  assign quad_a = phase_r[1];
  assign quad_b = phase_r[0];

endmodule

// File: rtl/cv_ctrl_ports.sv
// Controller-port front end: keypad/joystick leg mux into registered pins 1-4/6,
// plus one spinner quadrature emulator per port on pins 7/9.
module cv_ctrl_ports
  import cv_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int SPIN_DIV  = 64,
  parameter int ACC_MAX   = 127
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           ce_10m7,
  cv_ctrl_ports_if.slave bus
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [NUM_KEYS_C-1:0] keys_s;
    logic [4:0]            key_leg_s, joy_leg_s, leg_s;
    logic [3:0]            p1_4_r;
    logic                  p6_r;
    logic                  quad_a_s, quad_b_s;
    logic                  unused_s;

    // Legs are {p1,p2,p3,p4,p6}; a deselected leg is all ones so the AND ignores it
    always_comb begin
      keys_s = {bus.joystick[i][JOY_BLUE_C], bus.joystick[i][JOY_PURPLE_C],
                bus.joystick[i][JOY_HASH_C], bus.joystick[i][JOY_STAR_C],
                bus.joystick[i][JOY_KEY0_C +: 10]};
      key_leg_s = 5'b11111;
      if (!bus.ctrl_p5_n[i]) begin
        key_leg_s = {key_code(keys_s), ~bus.joystick[i][JOY_FIRE2_C]};
      end else begin
        key_leg_s = 5'b11111;
      end
      joy_leg_s = 5'b11111;
      if (!bus.ctrl_p8_n[i]) begin
        joy_leg_s = ~{bus.joystick[i][JOY_U_C], bus.joystick[i][JOY_D_C],
                      bus.joystick[i][JOY_L_C], bus.joystick[i][JOY_R_C],
                      bus.joystick[i][JOY_FIRE1_C]};
      end else begin
        joy_leg_s = 5'b11111;
      end
      leg_s = key_leg_s & joy_leg_s;
    end

    // Pin output registers
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        p1_4_r <= 4'b1111;
        p6_r   <= 1'b1;
      end else begin
        p1_4_r <= leg_s[4:1];
        p6_r   <= leg_s[0];
      end
    end

    cv_spin_quad #(
      .SPIN_DIV (SPIN_DIV),
      .ACC_MAX  (ACC_MAX)
    ) u_spin (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ce_10m7 (ce_10m7),
      .spin_en (bus.spin_en[i]),
      .spinner (bus.spinner[i]),
      .quad_a  (quad_a_s),
      .quad_b  (quad_b_s)
    );

    assign bus.ctrl_p1_4[i] = p1_4_r;
    assign bus.ctrl_p6[i]   = p6_r;
    assign bus.ctrl_p7[i]   = quad_a_s;
    assign bus.ctrl_p9[i]   = quad_b_s;
    assign unused_s         = &{1'b0, bus.joystick[i][31:20]};
  end

endmodule

// File: doc/cv_ctrl_ports.md
# cv_ctrl_ports

Parametrised controller-port front end for the ColecoVision/ADAM console core. It sits between the frontend inputs (`joystick_N`, `spinner_N`) and the `cv_console` controller pins (`ctrl_p1..p9`). It handles `NUM_PORTS` ports and registers all pin outputs. It adds a per-port Roller/Super Action spinner emulation: quadrature pulses on pins 7/9, driven by a saturating movement accumulator.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of controller ports (1..4).
- `SPIN_DIV`, 64: `ce_10m7` pulses between quadrature steps (≥2).
- `ACC_MAX`, 127: accumulator saturation magnitude.

Ports:
- `clk_sys` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `ce_10m7` in 1: console clock enable; paces the spinner stepping.
- `joystick` in `[NUM_PORTS][31:0]`: frontend buttons. Bits [3:0] are R,L,D,U. [4] fire1, [5] fire2, [6] `*`, [7] `#`, [17:8] keys 0-9, [18] purple, [19] blue.
- `spinner` in `[NUM_PORTS][8:0]`: [7:0] signed delta; [8] toggles on each new sample.
- `spin_en` in `[NUM_PORTS]`: 1 enables spinner emulation for that port.
- `ctrl_p5_n` in `[NUM_PORTS]`: keypad select, active low.
- `ctrl_p8_n` in `[NUM_PORTS]`: joystick select, active low.
- `ctrl_p1_4` out `[NUM_PORTS][3:0]`: pins {1,2,3,4}, active low.
- `ctrl_p6` out `[NUM_PORTS]`: fire pin, active low.
- `ctrl_p7` out `[NUM_PORTS]`: quadrature A.
- `ctrl_p9` out `[NUM_PORTS]`: quadrature B.

## Operation
- **Keypad leg** (`ctrl_p5_n[i]`=0):
  - Priority-encode keys in this order, highest first: 0-9, `*`, `#`, purple, blue.
  - Map the winning key to its 4-bit code from the package table. Example: 5→1001, none→1111.
  - The leg's p6 is `~joystick[i][5]`.
- **Joystick leg** (`ctrl_p8_n[i]`=0):
  - Pins 1-4 are `~{U,D,L,R}`, i.e. `~joystick[i][3:0]` reversed: p1=`~U`, p2=`~D`, p3=`~L`, p4=`~R`.
  - The leg's p6 is `~joystick[i][4]`.
- **Combining legs**: when both selects are low, pins 1-4 and p6 are the bitwise AND of both legs. A deselected leg contributes all-ones.
- **Spinner accumulator**: signed, `$clog2(ACC_MAX+1)+1` bits per port.
  - A sample is new when `spinner[i][8]` differs from its stored copy.
  - On a new sample the accumulator becomes sat(acc + sign-extended delta − step), where step is ±1 if a quadrature step fires in the same cycle, else 0.
  - Saturation is to ±`ACC_MAX`.
- **Stepper**: a per-port counter counts `ce_10m7` pulses up to `SPIN_DIV`.
  - At terminal count with acc≠0: advance the phase one position toward the sign of acc, then move acc one toward 0.
  - At terminal count with acc=0: no change. The counter wraps to 0 either way.
  - Forward phase sequence (A,B): 11→01→00→10→11. Reverse walks the same sequence backward.
- **Spinner disabled** (`spin_en[i]`=0): acc and counter are forced to 0 and the phase to 11. The toggle copy still tracks its input.

## Timing
- All outputs are registered. Pin changes appear one `clk_sys` cycle after the input or select change.
- Reset values:
  - `ctrl_p1_4`=4'b1111, `ctrl_p6`=1, `ctrl_p7`=`ctrl_p9`=1.
  - acc=0, counter=0, phase=11.
- On reset the toggle copy loads the current `spinner[i][8]`, so no spurious sample is taken after reset.
- A quadrature step changes exactly one of p7/p9, on the cycle after the terminal `ce_10m7`.
- Minimum spacing between steps is `SPIN_DIV` ce pulses.
- A new sample and a step in the same cycle are both applied, with a single saturation.
- A new sample with delta 0 changes nothing.
- Reset asserted mid-stepping returns the port to its reset values on the next edge.
- Clearing `spin_en` takes effect on the next edge.

## Structure
- Package `cv_ctrl_pkg` holds:
  - `cv_key_*_c` codes and a 14-entry key-code array.
  - The joystick bit-index constants.
  - The phase typedef (`logic [1:0]`) with `PH_IDLE`=2'b11.
- Sub-module `cv_spin_quad` is one per port, generated `NUM_PORTS` times. It contains the accumulator, counter and phase.
- The top level holds the keypad/joystick mux and the output registers.

## Test plan
- **Keypad**: reset, `ctrl_p5_n[0]`=0, key 5 pressed (joystick[0][13]=1) → `ctrl_p1_4[0]`=1001 next cycle; release → 1111.
- **Priority and AND**:
  - Keys 3 and 7 pressed together → 0110 (key 3).
  - With both selects low, fire2 + U → p6=0 and pins = keypad code AND 0111.
- **Spinner forward**: `SPIN_DIV`=4, `spin_en`=1, delta +3 with toggle → exactly 3 phase steps 11→01→00→10, spaced 4 ce pulses apart, then idle with acc=0.
- **Saturation and reverse**: deliver +100 twice → acc=127; then −128 → acc=−1, and one reverse step follows.
- **Reset mid-operation**: assert reset while acc=50 → next cycle p7=p9=1 and acc=0. A toggle held unchanged across reset produces no steps.
- **Multi-port**: `NUM_PORTS`=4 with independent stimuli per port → no cross-port interaction.
